// File: rtl/image_stream_pkg.sv
// image_stream_pkg: shared types and helpers for the image stream transmitter.
package image_stream_pkg;
  typedef enum logic {TX_IDLE, TX_RUN} tx_state_e;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/image_stream_if.sv
// Interface_Image: raster video stream bundle between producers and FAST/ORB consumers.
interface Interface_Image #(parameter int Pra_Width = 8);
  logic                 image_vs;
  logic                 image_hs;
  logic                 image_en;
  logic [Pra_Width-1:0] image_data;
  modport O_Image (output image_vs, image_hs, image_en, image_data);
  modport I_Image (input image_vs, image_hs, image_en, image_data);
endinterface

// File: rtl/image_timing_cnt.sv
// image_timing_cnt: free-running h/v raster counters with line and frame end flags.
module image_timing_cnt #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HW      = 10,
  parameter int VW      = 10
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_run,
  output logic [HW-1:0] O_h_cnt,
  output logic [VW-1:0] O_v_cnt,
  output logic          O_last_line,
  output logic          O_last_frame
);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  assign O_h_cnt      = r_h;
  assign O_v_cnt      = r_v;
  assign O_last_line  = r_h == H_LAST;
  assign O_last_frame = O_last_line && (r_v == V_LAST);
  // Counters only advance while running; the frame-end wrap leaves them at 0 for the next start.
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (I_run) begin
      r_h <= O_last_line ? '0 : r_h + 1'b1;
      if (O_last_line) r_v <= O_last_frame ? '0 : r_v + 1'b1;
    end
endmodule

// File: rtl/image_stream_tx.sv
// image_stream_tx: drives Interface_Image raster timing from a valid/ready pixel source.
module image_stream_tx
  import image_stream_pkg::*;
#(
  parameter int Pra_Width = 8,
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int HS_LEN    = 16,
  parameter int V_ACTIVE  = 480,
  parameter int V_BLANK   = 45,
  parameter int VS_LEN    = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_enable,
  input  logic [Pra_Width-1:0] I_pix_data,
  input  logic                 I_pix_valid,
  output logic                 O_pix_ready,
  Interface_Image.O_Image      O_Image_Stream,
  output logic                 O_busy,
  output logic                 O_frame_done,
  output logic                 O_underrun,
  output logic [15:0]          O_underrun_cnt
);
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam logic [HW-1:0] HS_C = HW'(HS_LEN);
  localparam logic [HW-1:0] HB_C = HW'(H_BLANK);
  localparam logic [VW-1:0] VS_C = VW'(VS_LEN);
  localparam logic [VW-1:0] VB_C = VW'(V_BLANK);
  tx_state_e            r_state;
  logic                 r_vs, r_hs, r_en, r_busy, r_frame_done, r_underrun;
  logic [Pra_Width-1:0] r_data;
  logic [15:0]          r_underrun_cnt;
  logic [HW-1:0]        w_h;
  logic [VW-1:0]        w_v;
  logic                 w_last_line, w_last_frame, w_run, w_vs, w_hs, w_en, w_under;
  image_timing_cnt #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HW(HW), .VW(VW)) u_cnt (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_run       (w_run),
    .O_h_cnt     (w_h),
    .O_v_cnt     (w_v),
    .O_last_line (w_last_line),
    .O_last_frame(w_last_frame)
  );
  assign w_run   = r_state == TX_RUN;
  assign w_vs    = w_run && (w_v < VS_C);
  assign w_hs    = w_run && (w_h < HS_C);
  assign w_en    = w_run && (w_h >= HB_C) && (w_v >= VB_C);
  assign w_under = w_en && !I_pix_valid;
  assign O_pix_ready    = w_en;
  assign O_busy         = r_busy;
  assign O_frame_done   = r_frame_done;
  assign O_underrun     = r_underrun;
  assign O_underrun_cnt = r_underrun_cnt;
  assign O_Image_Stream.image_vs   = r_vs;
  assign O_Image_Stream.image_hs   = r_hs;
  assign O_Image_Stream.image_en   = r_en;
  assign O_Image_Stream.image_data = r_data;
  // Timing never stalls on a missing pixel: the slot still goes out, just with zero data.
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_state        <= TX_IDLE;
      r_vs           <= 1'b0;
      r_hs           <= 1'b0;
      r_en           <= 1'b0;
      r_data         <= '0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_vs         <= w_vs;
      r_hs         <= w_hs;
      r_en         <= w_en;
      r_data       <= (w_en && I_pix_valid) ? I_pix_data : '0;
      r_busy       <= w_run;
      r_frame_done <= w_run && w_last_frame;
      r_underrun   <= w_under;
      if (w_under && r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (r_state == TX_IDLE && I_enable) r_state <= TX_RUN;
      else if (w_run && w_last_frame && !I_enable) r_state <= TX_IDLE;
    end
endmodule
